// File: rtl/byte_packer_if.sv
// Byte-in / word-out handshake bundle for byte_packer.
// slave is the packer's view, master is the producer/consumer side.
interface byte_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_word;
   logic        out_odd;
   logic [7:0]  out_cnt;

   modport slave (
      input  in_valid, in_byte, flush, out_ready,
      output in_ready, out_valid, out_word, out_odd, out_cnt
   );

   modport master (
      output in_valid, in_byte, flush, out_ready,
      input  in_ready, out_valid, out_word, out_odd, out_cnt
   );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: pairs signed bytes (low byte first) into 16-bit words held in a
// single-entry output register; flush emits a held odd byte as a padded word.
module byte_packer #(
   parameter bit PAD_SIGN = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   byte_packer_if.slave   bus
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HALF  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [7:0]  low_q, low_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_word_q, out_word_d;
   logic        out_odd_q, out_odd_d;
   logic [7:0]  out_cnt_q, out_cnt_d;

   logic        in_ready;
   logic        in_xfer;
   logic        out_xfer;
   logic        flush_fire;
   logic [7:0]  pad;

   // Handshake qualifiers; EMPTY always accepts since a low byte never needs the output slot.
   always_comb begin
      in_ready   = (state_q == EMPTY) || !out_valid_q || bus.out_ready;
      in_xfer    = bus.in_valid && in_ready;
      out_xfer   = out_valid_q && bus.out_ready;
      flush_fire = (state_q == HALF) && bus.flush && !in_xfer
                   && (!out_valid_q || bus.out_ready);
      pad        = PAD_SIGN ? {8{low_q[7]}} : 8'h00;
   end

   // Next-state: a load in the same cycle as a handoff overrides the clear, so no bubble.
   always_comb begin
      state_d     = state_q;
      low_d       = low_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      out_odd_d   = out_odd_q;
      out_cnt_d   = out_cnt_q;

      if (out_xfer) begin
         out_valid_d = 1'b0;
         out_cnt_d   = out_cnt_q + 8'd1;
      end

      if (state_q == EMPTY) begin
         if (in_xfer) begin
            low_d   = bus.in_byte;
            state_d = HALF;
         end
      end else if (in_xfer) begin
         out_word_d  = {bus.in_byte, low_q};
         out_odd_d   = 1'b0;
         out_valid_d = 1'b1;
         state_d     = EMPTY;
      end else if (flush_fire) begin
         out_word_d  = {pad, low_q};
         out_odd_d   = 1'b1;
         out_valid_d = 1'b1;
         state_d     = EMPTY;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         low_q       <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_odd_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         low_q       <= low_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_odd_q   <= out_odd_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_word  = out_word_q;
   assign bus.out_odd   = out_odd_q;
   assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: a sign-padding instance plus a zero-padding
// instance fed the same stimulus.
module tb_byte_packer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   byte_packer_if ba ();
   byte_packer_if bb ();

   byte_packer #(.PAD_SIGN(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
   byte_packer #(.PAD_SIGN(1'b0)) u_dut_z (.clk(clk), .rst_n(rst_n), .bus(bb.slave));

   assign bb.in_valid  = ba.in_valid;
   assign bb.in_byte   = ba.in_byte;
   assign bb.flush     = ba.flush;
   assign bb.out_ready = ba.out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One full clock: inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic f, input logic r);
      ba.in_valid  = v;
      ba.in_byte   = b;
      ba.flush     = f;
      ba.out_ready = r;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // reset values
      @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, ba.out_valid}, 32'd0);
      chk("rst_out_word",  {16'd0, ba.out_word},  32'h0);
      chk("rst_out_odd",   {31'd0, ba.out_odd},   32'd0);
      chk("rst_out_cnt",   {24'd0, ba.out_cnt},   32'd0);
      chk("rst_in_ready",  {31'd0, ba.in_ready},  32'd1);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, ba.in_ready}, 32'd1);

      // pairing 12,34
      drive(1'b1, 8'h12, 1'b0, 1'b1);
      tick();
      chk("pair_no_early_valid", {31'd0, ba.out_valid}, 32'd0);
      drive(1'b1, 8'h34, 1'b0, 1'b1);
      tick();
      chk("pair_valid", {31'd0, ba.out_valid}, 32'd1);
      chk("pair_word",  {16'd0, ba.out_word},  32'h3412);
      chk("pair_odd",   {31'd0, ba.out_odd},   32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("pair_cnt",   {24'd0, ba.out_cnt},   32'd1);
      chk("pair_drain", {31'd0, ba.out_valid}, 32'd0);

      // backpressure 01..04
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h04, 1'b0, 1'b0);
      #1;
      chk("bp_word_held", {16'd0, ba.out_word}, 32'h0201);
      chk("bp_in_ready0", {31'd0, ba.in_ready}, 32'd0);
      tick();
      chk("bp_word_stable", {16'd0, ba.out_word}, 32'h0201);
      chk("bp_valid_held",  {31'd0, ba.out_valid}, 32'd1);
      ba.out_ready = 1'b1;
      #1;
      chk("bp_in_ready1", {31'd0, ba.in_ready}, 32'd1);
      tick();
      chk("bp_no_bubble", {31'd0, ba.out_valid}, 32'd1);
      chk("bp_word2",     {16'd0, ba.out_word},  32'h0403);
      chk("bp_cnt2",      {24'd0, ba.out_cnt},   32'd2);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("bp_cnt3",  {24'd0, ba.out_cnt},   32'd3);
      chk("bp_clear", {31'd0, ba.out_valid}, 32'd0);

      // odd flush 9C, sign and zero pad
      drive(1'b1, 8'h9C, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      ba.flush = 1'b0;
      chk("flush_s_word",  {16'd0, ba.out_word},  32'hFF9C);
      chk("flush_s_odd",   {31'd0, ba.out_odd},   32'd1);
      chk("flush_s_valid", {31'd0, ba.out_valid}, 32'd1);
      chk("flush_z_word",  {16'd0, bb.out_word},  32'h009C);
      chk("flush_z_odd",   {31'd0, bb.out_odd},   32'd1);
      ba.out_ready = 1'b1;
      tick();
      chk("flush_cnt", {24'd0, ba.out_cnt}, 32'd4);

      // flush while EMPTY
      ba.flush = 1'b1;
      tick();
      tick();
      chk("empty_flush_valid", {31'd0, ba.out_valid}, 32'd0);
      chk("empty_flush_cnt",   {24'd0, ba.out_cnt},   32'd4);

      // byte and flush together in HALF
      drive(1'b1, 8'hAA, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'h55, 1'b1, 1'b1);
      tick();
      chk("simul_word", {16'd0, ba.out_word}, 32'h55AA);
      chk("simul_odd",  {31'd0, ba.out_odd},  32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      chk("simul_no_pad", {31'd0, ba.out_valid}, 32'd0);
      chk("simul_cnt",    {24'd0, ba.out_cnt},   32'd5);

      // byte and flush together in EMPTY, flush held
      drive(1'b1, 8'h33, 1'b1, 1'b1);
      tick();
      chk("empty_bf_no_word", {31'd0, ba.out_valid}, 32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      chk("empty_bf_word", {16'd0, ba.out_word}, 32'h0033);
      chk("empty_bf_odd",  {31'd0, ba.out_odd},  32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("empty_bf_cnt", {24'd0, ba.out_cnt}, 32'd6);

      // reset mid-word
      drive(1'b1, 8'h7E, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_cnt_async", {24'd0, ba.out_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      ba.flush = 1'b1;
      tick();
      ba.flush = 1'b0;
      chk("midrst_no_out", {31'd0, ba.out_valid}, 32'd0);
      chk("midrst_cnt",    {24'd0, ba.out_cnt},   32'd0);
      drive(1'b1, 8'h11, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'h22, 1'b0, 1'b1);
      tick();
      chk("midrst_word", {16'd0, ba.out_word}, 32'h2211);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("midrst_cnt1", {24'd0, ba.out_cnt}, 32'd1);

      // counter wrap: 254 more words to FF, one more to 00
      for (int i = 0; i < 254; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b1);
         tick();
         drive(1'b1, 8'(i + 1), 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("wrap_ff", {24'd0, ba.out_cnt}, 32'hFF);
      drive(1'b1, 8'hC3, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'h3C, 1'b0, 1'b1);
      tick();
      chk("wrap_word", {16'd0, ba.out_word}, 32'h3CC3);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("wrap_00", {24'd0, ba.out_cnt}, 32'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter: PAD_SIGN, default 1, odd-byte pad select (1 = sign-extend held byte, 0 = zero-fill).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  in_byte is presented.
REQ-005 Port: in_ready  output  1  packer can accept in_byte this cycle.
REQ-006 Port: in_byte  input  8  signed byte operand, low byte of a word arrives first.
REQ-007 Port: flush  input  1  level request to emit a held odd byte as a padded word.
REQ-008 Port: out_valid  output  1  out_word holds a packed word.
REQ-009 Port: out_ready  input  1  consumer accepts out_word this cycle.
REQ-010 Port: out_word  output  16  packed word: [7:0] first byte, [15:8] second byte.
REQ-011 Port: out_odd  output  1  out_word is a flushed single byte with padded [15:8].
REQ-012 Port: out_cnt  output  8  count of words handed off (out_valid & out_ready).

Function
REQ-013 State is held in a low-byte register plus a single-entry output register, giving states EMPTY (no low byte) and HALF (low byte held); out_valid is independent of that state.
REQ-014 An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-015 In EMPTY, in_ready is 1 regardless of the output register.
REQ-016 In EMPTY, an input transfer stores in_byte as the low byte and moves to HALF.
REQ-017 In HALF, in_ready = !out_valid | out_ready.
REQ-018 In HALF, an input transfer loads {in_byte, low byte} into out_word with out_odd=0, sets out_valid, and moves to EMPTY.
REQ-019 Latency: out_valid rises the cycle after the second byte's input transfer; out_word is stable while out_valid & !out_ready.
REQ-020 Flush fires in HALF when flush=1, there is no input transfer this cycle, and (!out_valid | out_ready).
REQ-021 When flush fires, out_word is loaded with {pad, low byte} and out_odd=1. pad = {8{low[7]}} if PAD_SIGN=1, else 8'h00. The state moves to EMPTY.
REQ-022 Same-cycle byte and flush in HALF: the byte completes a normal word and flush is ignored that cycle.
REQ-023 Same-cycle byte and flush in EMPTY: the byte is stored. If flush is still high next cycle, the padded word is emitted then.
REQ-024 flush in EMPTY has no effect and generates no word.
REQ-025 A simultaneous output transfer and new load replaces out_word with no bubble; out_valid stays 1.
REQ-026 An output transfer with no new load clears out_valid the next cycle.
REQ-027 out_cnt increments by 1 on each output transfer and wraps from 8'hFF to 8'h00.
REQ-028 No byte is dropped or duplicated under any combination of in_valid, out_ready, and flush.

Reset
REQ-029 While rst_n=0, the state is EMPTY, the low byte is 8'h00, out_valid=0, out_word=16'h0000, out_odd=0, and out_cnt=8'h00, all asynchronously.
REQ-030 in_ready=1 during and immediately after reset.
REQ-031 Reset asserted mid-word discards any held low byte and any pending output word without emitting it.
REQ-032 Reset release is sampled synchronously; the first input transfer may occur on the first rising edge with rst_n=1.

Verification
REQ-033 Pairing: bytes 8'h12 then 8'h34, out_ready=1 -> out_word=16'h3412, out_odd=0, out_valid one cycle after the second byte, out_cnt=1.
REQ-034 Backpressure: out_ready=0, bytes 8'h01, 8'h02, 8'h03, 8'h04 -> 16'h0201 held, in_ready=0 in HALF with low byte 8'h03. Raising out_ready -> 16'h0201 then 16'h0403 on consecutive cycles, no bubble.
REQ-035 Odd flush: PAD_SIGN=1, byte 8'h9C, then flush -> out_word=16'hFF9C, out_odd=1. PAD_SIGN=0 with the same stimulus -> 16'h009C.
REQ-036 Simultaneous: in HALF holding 8'hAA, byte 8'h55 with flush=1 -> out_word=16'h55AA, out_odd=0, no padded word follows.
REQ-037 Reset mid-word: byte 8'h7E, then rst_n=0, then release -> no output, out_cnt=0. Next bytes 8'h11, 8'h22 -> 16'h2211.
REQ-038 Wrap: 256 output transfers -> out_cnt returns to 8'h00.
